channel_error_injector: RTL and testbench

Parametrised, run-time configurable channel impairment block that sits between the convolutional encoder output and the Viterbi decoder input in the tx/rx test harness. It forwards one SYM_W-bit coded symbol per valid cycle and XOR-corrupts selected symbols under one of four modes: clean, periodic burst, LFSR random, or random-triggered burst. It limits injection to a programmable window and reports injected symbol and bit counts for BER checking.

---
 rtl/channel_error_injector.sv | 195 +++++++++++++++++++
 tb/tb_channel_error_injector.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/channel_error_injector.sv
// Channel impairment stage between the convolutional encoder and the Viterbi decoder:
// forwards coded symbols with one cycle of latency and XOR-corrupts selected ones.
module channel_error_injector #(
  parameter int          SYM_W = 2,
  parameter int          CNT_W = 16,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       mode_i,
  input  logic [CNT_W-1:0] period_i,
  input  logic [CNT_W-1:0] burst_len_i,
  input  logic [7:0]       rate_thresh_i,
  input  logic [SYM_W-1:0] err_mask_i,
  input  logic [CNT_W-1:0] window_i,
  input  logic             sym_valid_i,
  input  logic [SYM_W-1:0] sym_i,
  output logic             sym_valid_o,
  output logic [SYM_W-1:0] sym_o,
  output logic             err_flag_o,
  output logic [CNT_W-1:0] inj_sym_ct_o,
  output logic [CNT_W-1:0] bad_bit_ct_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [15:0] TAPS     = 16'hB400;

  localparam logic [1:0] MODE_CLEAN    = 2'd0;
  localparam logic [1:0] MODE_PERIODIC = 2'd1;
  localparam logic [1:0] MODE_RANDOM   = 2'd2;
  localparam logic [1:0] MODE_RBURST   = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] burst_len_q, burst_len_d;
  logic [7:0]       thresh_q, thresh_d;
  logic [SYM_W-1:0] mask_q, mask_d;
  logic [CNT_W-1:0] window_q, window_d;
  logic [CNT_W-1:0] pos_q, pos_d;
  logic [CNT_W-1:0] sym_cnt_q, sym_cnt_d;
  logic [CNT_W-1:0] remain_q, remain_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [CNT_W-1:0] inj_ct_q, inj_ct_d;
  logic [CNT_W-1:0] bad_ct_q, bad_ct_d;
  logic             sym_valid_q, sym_valid_d;
  logic [SYM_W-1:0] sym_q, sym_d;
  logic             err_q, err_d;

  logic             inject;
  logic             trigger;
  logic [15:0]      lfsr_step;
  logic [CNT_W:0]   mask_pop;
  logic [CNT_W:0]   bad_sum;

  always_comb begin
    mask_pop = '0;
    for (int i = 0; i < SYM_W; i++) begin
      mask_pop = mask_pop + (CNT_W + 1)'(mask_q[i]);
    end
  end

  assign lfsr_step = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
  // Random decisions use the LFSR value before this symbol's step.
  assign trigger   = (lfsr_q[7:0] < thresh_q);
  assign bad_sum   = {1'b0, bad_ct_q} + mask_pop;

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    period_d    = period_q;
    burst_len_d = burst_len_q;
    thresh_d    = thresh_q;
    mask_d      = mask_q;
    window_d    = window_q;
    pos_d       = pos_q;
    sym_cnt_d   = sym_cnt_q;
    remain_d    = remain_q;
    lfsr_d      = lfsr_q;
    inj_ct_d    = inj_ct_q;
    bad_ct_d    = bad_ct_q;
    sym_valid_d = sym_valid_i;
    sym_d       = sym_q;
    err_d       = 1'b0;
    inject      = 1'b0;

    if (state_q == RUN && sym_valid_i) begin
      unique case (mode_q)
        MODE_PERIODIC: begin
          if (period_q != '0) begin
            inject = (burst_len_q >= period_q) || (pos_q >= period_q - burst_len_q);
            pos_d  = (pos_q >= period_q - CNT_W'(1)) ? '0 : pos_q + CNT_W'(1);
          end
        end
        MODE_RANDOM: inject = trigger;
        MODE_RBURST: begin
          if (remain_q != '0) begin
            inject   = 1'b1;
            remain_d = remain_q - CNT_W'(1);
          end else if (trigger) begin
            inject   = 1'b1;
            remain_d = (burst_len_q == '0) ? '0 : burst_len_q - CNT_W'(1);
          end
        end
        default: inject = 1'b0;
      endcase

      lfsr_d    = lfsr_step;
      sym_cnt_d = sym_cnt_q + CNT_W'(1);
      if (inject) begin
        if (inj_ct_q != '1) inj_ct_d = inj_ct_q + CNT_W'(1);
        bad_ct_d = bad_sum[CNT_W] ? '1 : bad_sum[CNT_W-1:0];
      end
      if (window_q != '0 && sym_cnt_q == window_q - CNT_W'(1)) state_d = DONE;
    end

    if (sym_valid_i) begin
      sym_d = sym_i ^ (inject ? mask_q : '0);
      err_d = inject;
    end

    // A start pulse during RUN is ignored; the run only ends by window or reset.
    if (start_i && state_q != RUN) begin
      state_d     = RUN;
      mode_d      = mode_i;
      period_d    = period_i;
      burst_len_d = burst_len_i;
      thresh_d    = rate_thresh_i;
      mask_d      = err_mask_i;
      window_d    = window_i;
      pos_d       = '0;
      sym_cnt_d   = '0;
      remain_d    = '0;
      lfsr_d      = SEED_EFF;
      inj_ct_d    = '0;
      bad_ct_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mode_q      <= MODE_CLEAN;
      period_q    <= '0;
      burst_len_q <= '0;
      thresh_q    <= '0;
      mask_q      <= '0;
      window_q    <= '0;
      pos_q       <= '0;
      sym_cnt_q   <= '0;
      remain_q    <= '0;
      lfsr_q      <= SEED_EFF;
      inj_ct_q    <= '0;
      bad_ct_q    <= '0;
      sym_valid_q <= 1'b0;
      sym_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      period_q    <= period_d;
      burst_len_q <= burst_len_d;
      thresh_q    <= thresh_d;
      mask_q      <= mask_d;
      window_q    <= window_d;
      pos_q       <= pos_d;
      sym_cnt_q   <= sym_cnt_d;
      remain_q    <= remain_d;
      lfsr_q      <= lfsr_d;
      inj_ct_q    <= inj_ct_d;
      bad_ct_q    <= bad_ct_d;
      sym_valid_q <= sym_valid_d;
      sym_q       <= sym_d;
      err_q       <= err_d;
    end
  end

  assign sym_valid_o  = sym_valid_q;
  assign sym_o        = sym_q;
  assign err_flag_o   = err_q;
  assign inj_sym_ct_o = inj_ct_q;
  assign bad_bit_ct_o = bad_ct_q;
  assign busy_o       = (state_q == RUN);
  assign done_o       = (state_q == DONE);

endmodule

// File: tb/tb_channel_error_injector.sv
// Randomized scoreboard bench for channel_error_injector against a behavioural model.
module tb_channel_error_injector;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic [1:0]  mode_i = '0;
  logic [15:0] period_i = '0;
  logic [15:0] burst_len_i = '0;
  logic [7:0]  rate_thresh_i = '0;
  logic [1:0]  err_mask_i = '0;
  logic [15:0] window_i = '0;
  logic        sym_valid_i = 1'b0;
  logic [1:0]  sym_i = '0;
  logic        sym_valid_o;
  logic [1:0]  sym_o;
  logic        err_flag_o;
  logic [15:0] inj_sym_ct_o;
  logic [15:0] bad_bit_ct_o;
  logic        busy_o;
  logic        done_o;

  channel_error_injector #(.SYM_W(2), .CNT_W(16), .SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .mode_i(mode_i), .period_i(period_i),
    .burst_len_i(burst_len_i), .rate_thresh_i(rate_thresh_i), .err_mask_i(err_mask_i),
    .window_i(window_i), .sym_valid_i(sym_valid_i), .sym_i(sym_i),
    .sym_valid_o(sym_valid_o), .sym_o(sym_o), .err_flag_o(err_flag_o),
    .inj_sym_ct_o(inj_sym_ct_o), .bad_bit_ct_o(bad_bit_ct_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] sym;
    logic       err;
    int         idx;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int failures = 0;

  // Reference model: 0 idle, 1 running, 2 done
  int          m_state = 0;
  int          m_mode, m_period, m_burst, m_thresh, m_window;
  logic [1:0]  m_mask;
  int          m_idx, m_remain, m_inj, m_bad;
  logic [15:0] m_lfsr;
  int          out_idx = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  always @(negedge clk) begin
    if (sym_valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 32'(sym_o), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check($sformatf("sym[%0d]", e.idx), 32'(sym_o), 32'(e.sym));
        check($sformatf("err[%0d]", e.idx), 32'(err_flag_o), 32'(e.err));
      end
      out_idx++;
    end
  end

  task automatic model_sym(input logic [1:0] s, output logic inj);
    inj = 1'b0;
    if (m_state == 1) begin
      case (m_mode)
        1: if (m_period != 0) inj = ((m_idx % m_period) >= (m_period - m_burst));
        2: inj = (int'(m_lfsr[7:0]) < m_thresh);
        3: begin
          if (m_remain > 0) begin
            inj = 1'b1;
            m_remain--;
          end else if (int'(m_lfsr[7:0]) < m_thresh) begin
            inj = 1'b1;
            m_remain = (m_burst == 0) ? 0 : m_burst - 1;
          end
        end
        default: inj = 1'b0;
      endcase
      m_lfsr = lfsr_next(m_lfsr);
      if (inj) begin
        m_inj = (m_inj + 1 > 65535) ? 65535 : m_inj + 1;
        m_bad = (m_bad + $countones(m_mask) > 65535) ? 65535 : m_bad + $countones(m_mask);
      end
      m_idx++;
      if (m_window != 0 && m_idx == m_window) m_state = 2;
    end
  endtask

  task automatic send(input logic [1:0] s);
    logic inj;
    exp_t e;
    model_sym(s, inj);
    e.sym = s ^ (inj ? m_mask : 2'b00);
    e.err = inj;
    e.idx = m_idx - 1;
    exp_q.push_back(e);
    sym_valid_i = 1'b1;
    sym_i = s;
    @(posedge clk); #1;
    sym_valid_i = 1'b0;
    sym_i = 2'($urandom);
  endtask

  task automatic idle(input int n);
    sym_valid_i = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_start(input int mode, input int period, input int burst,
                          input int thresh, input logic [1:0] mask, input int window);
    mode_i = 2'(mode); period_i = 16'(period); burst_len_i = 16'(burst);
    rate_thresh_i = 8'(thresh); err_mask_i = mask; window_i = 16'(window);
    start_i = 1'b1;
    sym_valid_i = 1'b0;
    @(posedge clk); #1;
    start_i = 1'b0;
    if (m_state != 1) begin
      m_state = 1; m_mode = mode; m_period = period; m_burst = burst;
      m_thresh = thresh; m_mask = mask; m_window = window;
      m_idx = 0; m_remain = 0; m_inj = 0; m_bad = 0; m_lfsr = 16'hACE1;
    end
    // Scramble config inputs: they must only matter at the start pulse.
    mode_i = 2'($urandom); period_i = 16'($urandom); burst_len_i = 16'($urandom);
    rate_thresh_i = 8'($urandom); err_mask_i = 2'($urandom); window_i = 16'($urandom);
  endtask

  task automatic check_status(input string tag);
    check({tag, "_inj_ct"}, 32'(inj_sym_ct_o), 32'(m_inj));
    check({tag, "_bad_ct"}, 32'(bad_bit_ct_o), 32'(m_bad));
    check({tag, "_busy"}, 32'(busy_o), 32'(m_state == 1));
    check({tag, "_done"}, 32'(done_o), 32'(m_state == 2));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid_o"}, 32'(sym_valid_o), 32'h0);
    check({tag, "_sym_o"}, 32'(sym_o), 32'h0);
    check({tag, "_err_o"}, 32'(err_flag_o), 32'h0);
    check({tag, "_inj_ct"}, 32'(inj_sym_ct_o), 32'h0);
    check({tag, "_bad_ct"}, 32'(bad_bit_ct_o), 32'h0);
    check({tag, "_busy"}, 32'(busy_o), 32'h0);
    check({tag, "_done"}, 32'(done_o), 32'h0);
  endtask

  // The symbol presented with rst is in flight and must be dropped.
  task automatic apply_reset(input int cycles);
    rst = 1'b1;
    sym_valid_i = 1'b1;
    sym_i = 2'($urandom);
    repeat (cycles) begin
      @(posedge clk); #1;
    end
    m_state = 0; m_inj = 0; m_bad = 0;
    check_reset_outputs("reset");
    rst = 1'b0;
    sym_valid_i = 1'b0;
  endtask

  initial begin
    // 1. reset with valid input asserted
    apply_reset(2);

    // 2. clean mode, alternating symbols
    do_start(0, 0, 0, 0, 2'b11, 100);
    for (int i = 0; i < 100; i++) send((i % 2 == 0) ? 2'b01 : 2'b10);
    check_status("clean");
    check("clean_inj_zero", 32'(inj_sym_ct_o), 32'h0);

    // 3. periodic burst, continuous
    do_start(1, 32, 2, 0, 2'b11, 256);
    for (int i = 0; i < 300; i++) send(2'b00);
    check_status("periodic");
    check("periodic_inj16", 32'(inj_sym_ct_o), 32'd16);
    check("periodic_bad32", 32'(bad_bit_ct_o), 32'd32);
    check("periodic_done", 32'(done_o), 32'h1);

    // restart from DONE clears counters
    do_start(1, 32, 2, 0, 2'b11, 256);
    check_status("restart");
    check("restart_inj_clear", 32'(inj_sym_ct_o), 32'h0);

    // 4. same with gapped valid
    for (int i = 0; i < 300; i++) begin
      send(2'b00);
      idle(1);
      if (i % 50 == 0) check("gap_valid_o_low", 32'(sym_valid_o), 32'h0);
    end
    check_status("gapped");
    check("gapped_inj16", 32'(inj_sym_ct_o), 32'd16);
    check("gapped_bad32", 32'(bad_bit_ct_o), 32'd32);

    // 5a. random mode, thresh 0
    do_start(2, 0, 0, 0, 2'b11, 200);
    for (int i = 0; i < 200; i++) send(2'($urandom));
    check_status("rand_t0");
    check("rand_t0_none", 32'(inj_sym_ct_o), 32'h0);

    // 5b. random mode, thresh 64, unlimited window
    do_start(2, 0, 0, 64, 2'b01, 0);
    for (int i = 0; i < 1024; i++) send(2'($urandom));
    check_status("rand_t64");
    // start during RUN is ignored
    do_start(1, 4, 4, 0, 2'b11, 10);
    for (int i = 0; i < 50; i++) send(2'($urandom));
    check_status("start_in_run");
    idle(1);
    apply_reset(1);

    // 5c. random-triggered bursts
    do_start(3, 0, 4, 20, 2'($urandom_range(1, 3)), 1000);
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      send(2'($urandom));
    end
    check_status("rburst4");
    do_start(3, 0, 0, 40, 2'b10, 300);
    for (int i = 0; i < 300; i++) send(2'($urandom));
    check_status("rburst0");

    // 6. reset at symbol 100 of the periodic run
    do_start(1, 32, 2, 0, 2'b11, 256);
    for (int i = 0; i < 100; i++) send(2'b00);
    apply_reset(1);
    for (int i = 0; i < 10; i++) send(2'($urandom));
    check_status("idle_after_reset");

    // saturation
    do_start(1, 1, 1, 0, 2'b11, 0);
    for (int i = 0; i < 70000; i++) send(2'($urandom));
    check_status("saturate");
    check("sat_inj_ffff", 32'(inj_sym_ct_o), 32'hFFFF);
    check("sat_bad_ffff", 32'(bad_bit_ct_o), 32'hFFFF);

    idle(3);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
